// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg -- shared constants for the RV32I core-local interruptor (CLINT).
//
// Contents:
//   OFF_*           byte offsets of the CLINT registers (bits [1:0] ignored)
//   clint_reg_e     word index (offset[4:2]) of each mapped register
//   MTIMECMP_RESET  reset value of the 64-bit compare register
//
// Optional feature: CLINT_MTIME_WRITE_EN (see rv32i_clint.sv).
// ---------------------------------------------------------------------------
package rv32i_pkg;

  localparam logic [4:0] OFF_MSIP        = 5'h00;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h08;
  localparam logic [4:0] OFF_MTIME_LO    = 5'h0C;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h10;

  // Reset compare value: mtime can never exceed it, so no timer interrupt
  // fires until software programs a real deadline.
  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Word index of each mapped register; indices 5..7 are unmapped.
  typedef enum logic [2:0] {
    REG_MSIP        = OFF_MSIP[4:2],
    REG_MTIMECMP_LO = OFF_MTIMECMP_LO[4:2],
    REG_MTIMECMP_HI = OFF_MTIMECMP_HI[4:2],
    REG_MTIME_LO    = OFF_MTIME_LO[4:2],
    REG_MTIME_HI    = OFF_MTIME_HI[4:2]
  } clint_reg_e;

endpackage

// File: rtl/rv32i_clint_if.sv
// ---------------------------------------------------------------------------
// rv32i_clint_if -- simple strobe/ack register bus into the CLINT.
//
// Signals (named from the slave's point of view):
//   i_stb    request strobe, one request per cycle it is high
//   i_we     1 = write, 0 = read
//   i_addr   5-bit byte offset, bits [1:0] ignored
//   i_wdata  32-bit write data
//   o_rdata  32-bit read data, valid while o_ack = 1, otherwise 0
//   o_ack    one-cycle completion pulse, the cycle after i_stb
//
// Modports: master (bus initiator), slave (CLINT).
// ---------------------------------------------------------------------------
interface rv32i_clint_if;

  logic        i_stb;
  logic        i_we;
  logic [4:0]  i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ack;

  modport master (
    output i_stb, i_we, i_addr, i_wdata,
    input  o_rdata, o_ack
  );

  modport slave (
    input  i_stb, i_we, i_addr, i_wdata,
    output o_rdata, o_ack
  );

endinterface

// File: rtl/rv32i_mtime_counter.sv
// ---------------------------------------------------------------------------
// rv32i_mtime_counter -- prescaler plus free-running 64-bit mtime counter.
//
// Parameters:
//   PRESCALE  i_clk cycles per mtime increment (1..65535)
//
// Ports:
//   i_clk     rising-edge clock
//   i_rst_n   asynchronous active-low reset
//   i_wr_lo   load mtime[31:0] from i_wdata   (only with CLINT_MTIME_WRITE_EN)
//   i_wr_hi   load mtime[63:32] from i_wdata  (only with CLINT_MTIME_WRITE_EN)
//   i_wdata   write data                      (only with CLINT_MTIME_WRITE_EN)
//   o_mtime   current 64-bit mtime
//
// Macro CLINT_MTIME_WRITE_EN adds the write ports; otherwise mtime only counts.
// ---------------------------------------------------------------------------
module rv32i_mtime_counter #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
`ifdef CLINT_MTIME_WRITE_EN
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata,
`endif
  output logic [63:0] o_mtime
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_presc;
  logic [63:0]   r_mtime;
  logic          w_tick;

  // With PRESCALE = 1 the prescaler sits at 0 and every cycle is a tick.
  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // A bus write to either half wins over a same-cycle tick: the written half
  // takes the new value, the other half holds, and no carry propagates.
  // The prescaler keeps running so the tick rate is unaffected by writes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mtime <= '0;
`ifdef CLINT_MTIME_WRITE_EN
    end else if (i_wr_lo) begin
      r_mtime[31:0] <= i_wdata;
    end else if (i_wr_hi) begin
      r_mtime[63:32] <= i_wdata;
`endif
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  assign o_mtime = r_mtime;

endmodule

// File: rtl/rv32i_clint.sv
// ---------------------------------------------------------------------------
// rv32i_clint -- core-local interruptor: MSIP, MTIMECMP and MTIME registers.
//
// Register map (byte offsets, bits [1:0] ignored):
//   0x00 MSIP (bit 0)   0x04 MTIMECMP_LO   0x08 MTIMECMP_HI
//   0x0C MTIME_LO       0x10 MTIME_HI (returns the shadow latched on LO read)
//   0x14..0x1C unmapped: read 0, writes ignored, still acknowledged
//
// Parameters:
//   PRESCALE  i_clk cycles per mtime increment (1..65535)
//
// Ports:
//   i_clk                 rising-edge clock
//   i_rst_n               asynchronous active-low reset
//   bus                   rv32i_clint_if slave (stb/we/addr/wdata -> rdata/ack)
//   o_timer_interrupt     registered (mtime >= mtimecmp), level
//   o_software_interrupt  MSIP bit 0
//
// Macro CLINT_MTIME_WRITE_EN: when defined, MTIME_LO/HI are writable and a
// write takes priority over the same-cycle increment. When undefined, MTIME is
// read-only and writes to it are acknowledged and discarded.
// ---------------------------------------------------------------------------
module rv32i_clint
  import rv32i_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  rv32i_clint_if.slave bus,
  output logic         o_timer_interrupt,
  output logic         o_software_interrupt
);

  logic        r_msip;
  logic [63:0] r_mtimecmp;
  logic [31:0] r_shadow;
  logic [31:0] r_rdata;
  logic        r_ack;
  logic        r_tip;

  logic [2:0]  w_idx;
  logic        w_wr;
  logic        w_rd;
  logic [31:0] w_rdata_next;
  logic [63:0] w_mtime;

  assign w_idx = bus.i_addr[4:2];
  assign w_wr  = bus.i_stb & bus.i_we;
  assign w_rd  = bus.i_stb & ~bus.i_we;

`ifdef CLINT_MTIME_WRITE_EN
  logic w_wr_mtime_lo;
  logic w_wr_mtime_hi;

  assign w_wr_mtime_lo = w_wr && (w_idx == REG_MTIME_LO);
  assign w_wr_mtime_hi = w_wr && (w_idx == REG_MTIME_HI);

  rv32i_mtime_counter #(.PRESCALE(PRESCALE)) u_mtime (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr_lo (w_wr_mtime_lo),
    .i_wr_hi (w_wr_mtime_hi),
    .i_wdata (bus.i_wdata),
    .o_mtime (w_mtime)
  );
`else
  rv32i_mtime_counter #(.PRESCALE(PRESCALE)) u_mtime (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_mtime (w_mtime)
  );
`endif

  // Read mux; unmapped word indices fall through to 0.
  always_comb begin
    w_rdata_next = '0;
    case (w_idx)
      REG_MSIP:        w_rdata_next = {31'd0, r_msip};
      REG_MTIMECMP_LO: w_rdata_next = r_mtimecmp[31:0];
      REG_MTIMECMP_HI: w_rdata_next = r_mtimecmp[63:32];
      REG_MTIME_LO:    w_rdata_next = w_mtime[31:0];
      REG_MTIME_HI:    w_rdata_next = r_shadow;
      default:         w_rdata_next = '0;
    endcase
  end

  // Bus response: every strobe is acknowledged on the next cycle with no
  // wait states. Read data is only non-zero while the ack is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= bus.i_stb;
      r_rdata <= w_rd ? w_rdata_next : '0;
    end
  end

  // Writable registers. Latching MTIME_HI on a MTIME_LO read lets software
  // read a coherent 64-bit pair even if a carry lands between the two reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_msip     <= 1'b0;
      r_mtimecmp <= MTIMECMP_RESET;
      r_shadow   <= '0;
    end else begin
      if (w_wr && (w_idx == REG_MSIP)) begin
        r_msip <= bus.i_wdata[0];
      end
      if (w_wr && (w_idx == REG_MTIMECMP_LO)) begin
        r_mtimecmp[31:0] <= bus.i_wdata;
      end
      if (w_wr && (w_idx == REG_MTIMECMP_HI)) begin
        r_mtimecmp[63:32] <= bus.i_wdata;
      end
      if (w_rd && (w_idx == REG_MTIME_LO)) begin
        r_shadow <= w_mtime[63:32];
      end
    end
  end

  // Registered compare: the interrupt follows register changes one cycle late
  // and stays high for as long as the condition holds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tip <= 1'b0;
    end else begin
      r_tip <= (w_mtime >= r_mtimecmp);
    end
  end

  assign bus.o_ack            = r_ack;
  assign bus.o_rdata          = r_rdata;
  assign o_timer_interrupt    = r_tip;
  assign o_software_interrupt = r_msip;

endmodule

// File: tb/tb_rv32i_clint.sv
// ---------------------------------------------------------------------------
// tb_rv32i_clint -- self-checking bench for rv32i_clint.
//
// Two instances (PRESCALE = 1 and PRESCALE = 4) receive identical bus traffic.
// The reference model keeps mtime as a closed-form function of the number of
// clock edges since reset (base + floor(edges / PRESCALE)), plus the plain
// register contents. Build with CLINT_MTIME_WRITE_EN to also cover MTIME writes.
// ---------------------------------------------------------------------------
module tb_rv32i_clint;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv32i_clint_if bus1 ();
  rv32i_clint_if bus4 ();
  logic tip1, sip1, tip4, sip4;

  rv32i_clint #(.PRESCALE(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus1),
    .o_timer_interrupt(tip1), .o_software_interrupt(sip1)
  );

  rv32i_clint #(.PRESCALE(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus4),
    .o_timer_interrupt(tip4), .o_software_interrupt(sip4)
  );

  logic        ack_v [2];
  logic [31:0] rd_v  [2];
  logic        tip_v [2];
  logic        sip_v [2];
  assign ack_v[0] = bus1.o_ack;   assign ack_v[1] = bus4.o_ack;
  assign rd_v[0]  = bus1.o_rdata; assign rd_v[1]  = bus4.o_rdata;
  assign tip_v[0] = tip1;         assign tip_v[1] = tip4;
  assign sip_v[0] = sip1;         assign sip_v[1] = sip4;

  // Rising edges since reset release; after edge k this reads k.
  int unsigned cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state.
  longint unsigned m_base  [2];
  int unsigned     m_wedge [2];
  logic [63:0]     m_cmp;
  logic            m_msip;
  logic [31:0]     m_shadow[2];

  function automatic int unsigned ps(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // mtime value after clock edge k.
  function automatic logic [63:0] mtime_at(input int i, input int unsigned k);
    return m_base[i] + 64'(k / ps(i)) - 64'(m_wedge[i] / ps(i));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_base[i] = 0; m_wedge[i] = 0; m_shadow[i] = '0;
    end
    m_cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
    m_msip = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic drive(input logic stb, input logic we, input logic [4:0] a, input logic [31:0] d);
    bus1.i_stb = stb; bus1.i_we = we; bus1.i_addr = a; bus1.i_wdata = d;
    bus4.i_stb = stb; bus4.i_we = we; bus4.i_addr = a; bus4.i_wdata = d;
  endtask

  // One bus transaction on both DUTs, called at a falling edge.
  task automatic txn(input logic we, input logic [4:0] a, input logic [31:0] d);
    logic [31:0] exp_rd [2];
    logic        exp_tip[2];
    logic [63:0] mt;
    int unsigned k;
    drive(1'b1, we, a, d);
    @(posedge clk); #1;
    k = cyc;
    for (int i = 0; i < 2; i++) begin
      mt = mtime_at(i, k - 1);
      exp_tip[i] = (mt >= m_cmp);
      exp_rd[i]  = '0;
      if (!we) begin
        case (a & 5'h1C)
          OFF_MSIP:        exp_rd[i] = {31'd0, m_msip};
          OFF_MTIMECMP_LO: exp_rd[i] = m_cmp[31:0];
          OFF_MTIMECMP_HI: exp_rd[i] = m_cmp[63:32];
          OFF_MTIME_LO:    begin exp_rd[i] = mt[31:0]; m_shadow[i] = mt[63:32]; end
          OFF_MTIME_HI:    exp_rd[i] = m_shadow[i];
          default:         exp_rd[i] = '0;
        endcase
      end
    end
    if (we) begin
      case (a & 5'h1C)
        OFF_MSIP:        m_msip = d[0];
        OFF_MTIMECMP_LO: m_cmp[31:0] = d;
        OFF_MTIMECMP_HI: m_cmp[63:32] = d;
`ifdef CLINT_MTIME_WRITE_EN
        OFF_MTIME_LO, OFF_MTIME_HI: begin
          for (int i = 0; i < 2; i++) begin
            mt = mtime_at(i, k - 1);
            m_base[i]  = ((a & 5'h1C) == OFF_MTIME_LO) ? {mt[63:32], d} : {d, mt[31:0]};
            m_wedge[i] = k;
          end
        end
`endif
        default: ;
      endcase
    end
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ack_p%0d", ps(i)), ack_v[i], 1'b1);
      if (!we) chk($sformatf("rdata_p%0d@%02h", ps(i), a), rd_v[i], exp_rd[i]);
      chk($sformatf("tip_p%0d", ps(i)), tip_v[i], exp_tip[i]);
      chk($sformatf("sip_p%0d", ps(i)), sip_v[i], m_msip);
    end
    $display("txn edge=%0d we=%0b addr=%02h wdata=%08h rdata_p1=%08h rdata_p4=%08h tip=%0b/%0b sip=%0b/%0b",
             k, we, a, d, rd_v[0], rd_v[1], tip_v[0], tip_v[1], sip_v[0], sip_v[1]);
  endtask

  // Idle cycles: no ack, zero read data, interrupts track the model.
  task automatic idle(input int n);
    logic        exp_tip[2];
    int unsigned k;
    repeat (n) begin
      @(posedge clk); #1;
      k = cyc;
      for (int i = 0; i < 2; i++) exp_tip[i] = (mtime_at(i, k - 1) >= m_cmp);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("idle_ack_p%0d", ps(i)), ack_v[i], 1'b0);
        chk($sformatf("idle_rdata_p%0d", ps(i)), rd_v[i], 32'd0);
        chk($sformatf("idle_tip_p%0d", ps(i)), tip_v[i], exp_tip[i]);
        chk($sformatf("idle_sip_p%0d", ps(i)), sip_v[i], m_msip);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_ack_p%0d", tag, ps(i)), ack_v[i], 1'b0);
      chk($sformatf("%s_rdata_p%0d", tag, ps(i)), rd_v[i], 32'd0);
      chk($sformatf("%s_tip_p%0d", tag, ps(i)), tip_v[i], 1'b0);
      chk($sformatf("%s_sip_p%0d", tag, ps(i)), sip_v[i], 1'b0);
    end
  endtask

  initial begin
    logic [4:0]  a;
    logic [31:0] d;
    logic [63:0] mt;
    logic        we;

    drive(1'b0, 1'b0, 5'd0, 32'd0);
    model_reset();
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset then idle: mtime counts from 0, no timer interrupt.
    for (int j = 0; j < 4; j++) txn(1'b0, OFF_MTIME_LO, 32'd0);
    idle(3);
    txn(1'b0, OFF_MTIME_HI, 32'd0);
    txn(1'b0, OFF_MTIMECMP_LO, 32'd0);

    // Deadline at mtime = 20.
    txn(1'b1, OFF_MTIMECMP_HI, 32'd0);
    txn(1'b1, OFF_MTIMECMP_LO, 32'd20);
    idle(25);
    chk("tip_hold_p1", tip1, 1'b1);

    // Software interrupt: only bit 0 is stored.
    txn(1'b1, OFF_MSIP, 32'hFFFF_FFFF);
    txn(1'b0, OFF_MSIP, 32'd0);
    txn(1'b1, OFF_MSIP, 32'd0);
    idle(1);

`ifdef CLINT_MTIME_WRITE_EN
    // Carry from a written MTIME_LO, then a coherent LO/HI read pair.
    txn(1'b1, OFF_MTIME_HI, 32'd0);
    txn(1'b1, OFF_MTIME_LO, 32'hFFFF_FFFF);
    idle(1);
    txn(1'b0, OFF_MTIME_LO, 32'd0);
    chk("carry_lo_p1", rd_v[0], 32'd0);
    txn(1'b0, OFF_MTIME_HI, 32'd0);
    chk("carry_hi_p1", rd_v[0], 32'd1);
`endif

    // Unmapped offsets and ignored low address bits; prescaled counting.
    txn(1'b0, 5'h18, 32'd0);
    txn(1'b1, 5'h14, 32'hDEAD_BEEF);
    txn(1'b0, 5'h1F, 32'd0);
    txn(1'b0, 5'h0F, 32'd0);
    for (int j = 0; j < 6; j++) txn(1'b0, OFF_MTIME_LO, 32'd0);

    // Randomized traffic against the model.
    for (int j = 0; j < 200; j++) begin
      a  = 5'($urandom_range(0, 31));
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      mt = mtime_at(int'($urandom_range(0, 1)), cyc);
      case (a & 5'h1C)
        OFF_MTIMECMP_LO: d = mt[31:0] + 32'($urandom_range(0, 30));
        OFF_MTIMECMP_HI: d = ($urandom_range(0, 3) == 0) ? $urandom : mt[63:32];
        OFF_MTIME_HI:    d = 32'($urandom_range(0, 1));
        default: ;
      endcase
      txn(we, a, d);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    // Reset in the middle of a request, with both interrupts active.
    txn(1'b1, OFF_MTIMECMP_HI, 32'd0);
    txn(1'b1, OFF_MTIMECMP_LO, 32'd0);
    txn(1'b1, OFF_MSIP, 32'd1);
    idle(2);
    drive(1'b1, 1'b0, OFF_MTIME_LO, 32'd0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("mid");
    @(posedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    txn(1'b0, OFF_MTIMECMP_LO, 32'd0);
    chk("rst_cmp_lo_p1", rd_v[0], 32'hFFFF_FFFF);
    txn(1'b0, OFF_MTIMECMP_HI, 32'd0);
    chk("rst_cmp_hi_p1", rd_v[0], 32'hFFFF_FFFF);
    txn(1'b0, OFF_MTIME_LO, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
